// File: rtl/rvga_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rvga_lsu_pkg
//  Desc   : Shared types and helpers for the MEM-stage load/store unit.
//  Rev    : 1.0  initial release
// ============================================================================
package rvga_lsu_pkg;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_X} mem_size_t;

    typedef enum logic [1:0] {LSU_IDLE, LSU_WAIT, LSU_RESP, LSU_FAULT} lsu_state_t;

    // True when the access cannot be issued: illegal size or unnatural alignment
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = addr_lo[0];
            MEM_W:   bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvga_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module : rvga_lsu_align
//  Desc   : Combinational lane logic. Store side builds byte enables and
//           lane-replicated write data; load side shifts and extends the word.
//  Rev    : 1.0  initial release
// ============================================================================
module rvga_lsu_align
    import rvga_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_size_t         st_size,
    input  logic [1:0]        st_addr_lo,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [3:0]        st_be,
    output logic [XLEN-1:0]   st_wdata_rep,
    output logic              st_misaligned,
    input  mem_size_t         ld_size,
    input  logic [1:0]        ld_addr_lo,
    input  logic              ld_unsigned,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0] shifted;
    logic            sext_b;
    logic            sext_h;

    // Store path: enables and replication depend only on size and low address
    always_comb begin
        st_be         = 4'b0000;
        st_wdata_rep  = st_wdata;
        st_misaligned = is_misaligned(st_size, st_addr_lo);
        case (st_size)
            MEM_B: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_wdata_rep = {(XLEN/8){st_wdata[7:0]}};
            end
            MEM_H: begin
                st_be        = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata_rep = {(XLEN/16){st_wdata[15:0]}};
            end
            MEM_W: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: begin
                st_be        = 4'b0000;
                st_wdata_rep = st_wdata;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        sext_b  = ~ld_unsigned & shifted[7];
        sext_h  = ~ld_unsigned & shifted[15];
        case (ld_size)
            MEM_B:   ld_data = {{(XLEN-8){sext_b}}, shifted[7:0]};
            MEM_H:   ld_data = {{(XLEN-16){sext_h}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rvga_lsu.sv
`default_nettype none
// ============================================================================
//  Module : rvga_lsu
//  Desc   : MEM-stage load/store unit. Accepts one request from EX, runs a
//           req/ack transaction on the data port, returns aligned load data.
//  Rev    : 1.0  initial release
// ============================================================================
module rvga_lsu
    import rvga_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              misalign
);

    lsu_state_t      state_q;
    lsu_state_t      state_d;
    logic            accept;
    logic            ack_hit;
    logic            we_q;
    logic            unsigned_q;
    mem_size_t       size_q;
    logic [1:0]      addr_lo_q;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata_rep;
    logic            st_misaligned;
    logic [XLEN-1:0] ld_data;

    // Ready is withheld while reset is asserted even though the state is IDLE
    assign req_ready = (state_q == LSU_IDLE) & rst_n;
    assign accept    = req_valid & req_ready;
    assign mem_req   = (state_q == LSU_WAIT);
    assign mem_we    = mem_req & we_q;
    assign ack_hit   = mem_req & mem_ack;
    assign rsp_valid = (state_q == LSU_RESP);
    assign misalign  = (state_q == LSU_FAULT);

    rvga_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_size       (mem_size_t'(req_size)),
        .st_addr_lo    (req_addr[1:0]),
        .st_wdata      (req_wdata),
        .st_be         (st_be),
        .st_wdata_rep  (st_wdata_rep),
        .st_misaligned (st_misaligned),
        .ld_size       (size_q),
        .ld_addr_lo    (addr_lo_q),
        .ld_unsigned   (unsigned_q),
        .ld_rdata      (mem_rdata),
        .ld_data       (ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LSU_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:  if (accept) state_d = st_misaligned ? LSU_FAULT : LSU_WAIT;
            LSU_WAIT:  if (mem_ack) state_d = LSU_RESP;
            LSU_RESP:  state_d = LSU_IDLE;
            LSU_FAULT: state_d = LSU_IDLE;
            default:   state_d = LSU_IDLE;
        endcase
    end

    // Request capture on accept and load-data capture on ack; all held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rsp_rdata  <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= MEM_B;
            addr_lo_q  <= 2'b00;
        end else begin
            if (accept && !st_misaligned) begin
                mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_be     <= st_be;
                mem_wdata  <= st_wdata_rep;
                we_q       <= req_we;
                unsigned_q <= req_unsigned;
                size_q     <= mem_size_t'(req_size);
                addr_lo_q  <= req_addr[1:0];
            end
            if (ack_hit) begin
                rsp_rdata <= we_q ? '0 : ld_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvga_lsu.sv
`default_nettype none
// ============================================================================
//  Module : tb_rvga_lsu
//  Desc   : Directed self-checking bench for rvga_lsu.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_rvga_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rvga_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .misalign     (misalign)
    );

    // Single comparison point: counts and reports
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Full transaction with a given number of wait cycles before ack
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rsp);
        check_eq({tag, ".ready_pre"}, {31'b0, req_ready}, 32'd1);
        present(we, size, uns, addr, wdata);
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        for (int i = 0; i <= waits; i++) begin
            check_eq({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
            check_eq({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, we});
            check_eq({tag, ".mem_addr"}, mem_addr, exp_addr);
            check_eq({tag, ".mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
            if (we) check_eq({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
            check_eq({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
            check_eq({tag, ".rsp_early"}, {31'b0, rsp_valid}, 32'd0);
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_0000;
        check_eq({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_eq({tag, ".rsp_rdata"}, rsp_rdata, exp_rsp);
        check_eq({tag, ".mem_req_off"}, {31'b0, mem_req}, 32'd0);
        step();
        check_eq({tag, ".rsp_pulse"}, {31'b0, rsp_valid}, 32'd0);
        check_eq({tag, ".rsp_hold"}, rsp_rdata, exp_rsp);
        check_eq({tag, ".ready_post"}, {31'b0, req_ready}, 32'd1);
    endtask

    // Request expected to fault without touching memory
    task automatic do_fault(input string tag, input logic [1:0] size, input logic [31:0] addr);
        present(1'b0, size, 1'b0, addr, 32'h0);
        step();
        req_valid = 1'b0;
        check_eq({tag, ".misalign"}, {31'b0, misalign}, 32'd1);
        check_eq({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
        check_eq({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
        step();
        check_eq({tag, ".misalign_pulse"}, {31'b0, misalign}, 32'd0);
        check_eq({tag, ".mem_req_after"}, {31'b0, mem_req}, 32'd0);
        check_eq({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check_eq({tag, ".ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst.mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst.mem_be", {28'b0, mem_be}, 32'd0);
        check_eq("rst.mem_addr", mem_addr, 32'd0);
        check_eq("rst.rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst.misalign", {31'b0, misalign}, 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rst.req_ready", {31'b0, req_ready}, 32'd1);

        // Loads and stores with zero-wait memory
        do_access("LB",  1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8000_0000, 0,
                  32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("LHU", 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0,
                  32'h0000_0100, 4'b1100, 32'h0, 32'h0000_BEEF);
        do_access("SB",  1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h1111_1111, 0,
                  32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 32'h0);
        do_access("LH",  1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_F00D, 0,
                  32'h0000_0100, 4'b0011, 32'h0, 32'hFFFF_F00D);
        do_access("LBU", 1'b0, 2'b00, 1'b1, 32'h0000_0402, 32'h0, 32'h00C3_0000, 0,
                  32'h0000_0400, 4'b0100, 32'h0, 32'h0000_00C3);
        do_access("SH",  1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_CAFE, 32'h0, 0,
                  32'h0000_0100, 4'b1100, 32'hCAFE_CAFE, 32'h0);
        do_access("SW",  1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0, 1,
                  32'h0000_0204, 4'b1111, 32'hDEAD_BEEF, 32'h0);

        // Misaligned and illegal-size requests
        do_fault("LW_mis", 2'b10, 32'h0000_0102);
        do_fault("LH_mis", 2'b01, 32'h0000_0101);
        do_fault("SIZE11", 2'b11, 32'h0000_0100);

        // Word load with three wait cycles
        do_access("LW_wait", 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 3,
                  32'h0000_0200, 4'b1111, 32'h0, 32'h1234_5678);

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_eq("idle_ack.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("idle_ack.ready", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of a wait
        present(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        step();
        req_valid = 1'b0;
        check_eq("abort.mem_req_before", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort.mem_req_async", {31'b0, mem_req}, 32'd0);
        check_eq("abort.mem_addr_async", mem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_AAAA;
        step();
        mem_ack = 1'b0;
        check_eq("abort.late_ack_rsp", {31'b0, rsp_valid}, 32'd0);
        check_eq("abort.late_ack_req", {31'b0, mem_req}, 32'd0);
        step();
        check_eq("abort.no_rsp", {31'b0, rsp_valid}, 32'd0);
        check_eq("abort.rsp_rdata", rsp_rdata, 32'd0);
        do_access("LW_after", 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 0,
                  32'h0000_0200, 4'b1111, 32'h0, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
